// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: round-robin arbiter that feeds bytes from NREQ requesters to a
// single UART transmitter (load byte, strobe start, wait for frame done, one gap).
// Optional watchdog on the WAIT state is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd200000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [12:0]       cfg_div,
  output logic [7:0]        tx_data,
  output logic [12:0]       tx_div,
  output logic              tx_run_n,
  input  logic              tx_done,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              err_timeout
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       last_grant;
  logic [7:0]       valid_ext;
  logic [IDX_W-1:0] rr_idx;
  logic [1:0]       rr_winner;
  logic             rr_found;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             wdog_expired;

  // Round-robin search starting one past the last completed grant, with wrap.
  always_comb begin
    valid_ext = 8'(req_valid);
    rr_found  = 1'b0;
    rr_winner = last_grant;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = IDX_W'(last_grant) + IDX_W'(k);
      if (rr_idx >= IDX_W'(NREQ)) begin
        rr_idx = rr_idx - IDX_W'(NREQ);
      end
      if (!rr_found && valid_ext[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx[1:0];
      end
    end
  end

  // Valid bit and byte of the currently granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == 2'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; tx_done only matters in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rr_found) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = sel_valid ? ST_START : ST_IDLE;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (tx_done || wdog_expired) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Acceptance strobe: only in LOAD, only while the granted requester still holds valid.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rstn && (state == ST_LOAD) && (grant_id == 2'(i))) begin
        req_ready[i] = req_valid[i];
      end
    end
  end

  // Registered outputs and grant bookkeeping; tx_data/tx_div only change on a taken LOAD.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_id   <= 2'd0;
      last_grant <= 2'(NREQ - 1);
      tx_data    <= 8'h00;
      tx_div     <= 13'd0;
      tx_run_n   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && rr_found) begin
        grant_id <= rr_winner;
      end
      if ((state == ST_LOAD) && sel_valid) begin
        tx_data <= sel_data;
        tx_div  <= cfg_div;
      end
      if ((state == ST_WAIT) && (state_nxt == ST_GAP)) begin
        last_grant <= grant_id;
      end
      tx_run_n <= (state_nxt != ST_START);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [23:0] wdog_cnt;

  assign wdog_expired = (state == ST_WAIT) && !tx_done && (wdog_cnt == TIMEOUT_CYCLES);

  // WAIT watchdog: cleared on the way into WAIT, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wdog_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wdog_cnt <= wdog_cnt + 24'd1;
      end
      err_timeout <= wdog_expired;
    end
  end
`else
  // No watchdog: WAIT lasts until tx_done; the limit parameter has no effect.
  assign wdog_expired = 1'b0;
  assign err_timeout  = 1'b0 & (|TIMEOUT_CYCLES);
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters, range 2..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd200000: WAIT-state watchdog limit; used only with UART_ARB_TIMEOUT_EN.
REQ-003 Port clk  in  1: clock; all state updates on rising edge.
REQ-004 Port rstn  in  1: reset, synchronous, active-low.
REQ-005 Port req_valid  in  NREQ: requester i holds a byte pending.
REQ-006 Port req_data  in  8*NREQ: byte of requester i at bits [8i+7:8i].
REQ-007 Port req_ready  out  NREQ: one-hot acceptance strobe; the byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 Port cfg_div  in  13: clocks per bit for the next frame.
REQ-009 Port tx_data  out  8: byte driven to the transmitter.
REQ-010 Port tx_div  out  13: clocks per bit driven to the transmitter.
REQ-011 Port tx_run_n  out  1: active-low start strobe to the transmitter.
REQ-012 Port tx_done  in  1: transmitter frame-complete indication.
REQ-013 Port busy  out  1: high in every state except IDLE.
REQ-014 Port grant_id  out  2: index of the current or last granted requester.
REQ-015 Port err_timeout  out  1: one-cycle watchdog abort pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, START, WAIT and GAP, encoded in 3 bits.
REQ-017 IDLE: if any req_valid is high, grant_id <= round-robin winner and the FSM goes to LOAD; otherwise it stays in IDLE.
REQ-018 Round-robin search SHALL start at (last_grant+1) mod NREQ and ascend with wrap, so one requester can never win twice in a row while another is valid.
REQ-019 LOAD: req_ready[grant_id]=1 (combinational from state) for exactly 1 cycle; tx_data <= req_data[grant_id]; tx_div <= cfg_div; the FSM goes to START.
REQ-020 LOAD with req_valid[grant_id] low: req_ready stays 0, tx_data is unchanged, the FSM returns to IDLE and last_grant is unchanged.
REQ-021 START: tx_run_n=0 for exactly 1 cycle, then the FSM goes to WAIT.
REQ-022 tx_run_n SHALL be 1 in every state other than START.
REQ-023 WAIT: tx_run_n=1; on tx_done=1 the FSM goes to GAP and last_grant <= grant_id.
REQ-024 GAP: the FSM spends one idle cycle, then goes to IDLE, so there are at least 2 cycles from tx_done to the next START.
REQ-025 tx_data and tx_div SHALL stay constant from LOAD exit until the next LOAD.
REQ-026 Latency from valid seen in IDLE to tx_run_n low SHALL be 2 cycles (IDLE->LOAD->START).
REQ-027 A tx_done seen outside WAIT SHALL be ignored.
REQ-028 A cfg_div change outside LOAD SHALL have no effect on the frame in flight.

Reset
REQ-029 On rstn=0 at a rising edge the block SHALL set: state=IDLE, req_ready=0, tx_run_n=1, tx_data=8'h00, tx_div=13'd0, grant_id=0, err_timeout=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-030 A reset mid-frame SHALL abort immediately; no req_ready is issued for the aborted grant.

Configuration
REQ-031 Macro UART_ARB_TIMEOUT_EN defined: a 24-bit counter clears on WAIT entry and increments each WAIT cycle.
REQ-032 With UART_ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES without tx_done, err_timeout=1 for 1 cycle, the FSM goes to GAP and last_grant <= grant_id.
REQ-033 Macro UART_ARB_TIMEOUT_EN undefined: WAIT waits indefinitely, err_timeout is tied to 0 and no counter is built.

Verification
REQ-034 Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5, cfg_div=433 -> req_ready=4'b0001 one cycle, tx_data=8'hA5, tx_div=433, tx_run_n low exactly 1 cycle, 2 cycles after valid.
REQ-035 req_valid=4'b1111 held, tx_done pulsed 10 cycles after each START -> grant order 0,1,2,3,0, each with one req_ready pulse.
REQ-036 req_valid[2] only, dropped during LOAD -> no req_ready, return to IDLE, tx_run_n stays 1.
REQ-037 rstn=0 while in WAIT -> next cycle IDLE, tx_run_n=1, busy=0; a following req_valid=4'b0010 is served normally.
REQ-038 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50 and tx_done held 0 -> err_timeout pulses once 50 cycles after WAIT entry, then IDLE; without the macro -> remains in WAIT, err_timeout=0.
REQ-039 tx_done=1 pulsed in IDLE and in START -> ignored, no state change.
